// File: rtl/alu_share_arbiter.sv
// Round-robin share of one arithmetic unit; gnt one cycle after the request edge, rsp_valid LAT cycles after gnt.
// Requests are only sampled in IDLE, so requesters hold req/operands until gnt (no other backpressure).
module alu_share_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int MUL_LAT   = 2,
  parameter int DIV_LAT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [3*NREQ-1:0]         op,
  input  logic [DATAWIDTH*NREQ-1:0] a,
  input  logic [DATAWIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      rsp_valid,
  output logic [1:0]                rsp_id,
  output logic [DATAWIDTH-1:0]      rsp_data,
  output logic                      rsp_err
);
  localparam int IW     = 2;
  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t               r_state, w_next_state;
  logic [IW-1:0]        r_rr_ptr;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_op;
  logic [DATAWIDTH-1:0] r_a, r_b;
  logic [IW-1:0]        r_id;
  logic [NREQ-1:0]      r_gnt;
  logic                 r_rsp_valid;
  logic [IW-1:0]        r_rsp_id;
  logic [DATAWIDTH-1:0] r_rsp_data;
  logic                 r_rsp_err;

  logic                 w_found;
  logic [IW-1:0]        w_sel, w_idx;
  logic [2:0]           w_sel_op;
  logic [DATAWIDTH-1:0] w_sel_a, w_sel_b;
  logic [CW-1:0]        w_lat_m1;
  logic [DATAWIDTH-1:0] w_res;
  logic                 w_err;

  // Descending scan so the requester closest to r_rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = r_rr_ptr + IW'(k);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_sel_op = op[3*w_sel +: 3];
  assign w_sel_a  = a[DATAWIDTH*w_sel +: DATAWIDTH];
  assign w_sel_b  = b[DATAWIDTH*w_sel +: DATAWIDTH];

  always_comb begin
    w_lat_m1 = '0;
    case (w_sel_op)
      OP_MUL:         w_lat_m1 = CW'(MUL_LAT - 1);
      OP_DIV, OP_MOD: w_lat_m1 = CW'(DIV_LAT - 1);
      default:        w_lat_m1 = '0;
    endcase
  end

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (r_op)
      OP_ADD: w_res = r_a + r_b;
      OP_SUB: w_res = r_a - r_b;
      OP_MUL: w_res = r_a * r_b;
      OP_DIV: begin
        if (r_b == '0) begin
          w_res = '1;
          w_err = 1'b1;
        end else begin
          w_res = r_a / r_b;
        end
      end
      OP_MOD: begin
        if (r_b == '0) begin
          w_res = r_a;
          w_err = 1'b1;
        end else begin
          w_res = r_a % r_b;
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next_state = S_EXEC;
      S_EXEC:  if (r_cnt == '0) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op     <= w_sel_op;
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_id     <= w_sel;
            r_gnt    <= NREQ'(1) << w_sel;
            r_rr_ptr <= w_sel + IW'(1);
            r_cnt    <= w_lat_m1;
          end
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= w_res;
            r_rsp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter against a round-robin/arithmetic reference model.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] op;
  logic [31:0] a, b;
  logic [3:0]  gnt;
  logic        busy, rsp_valid, rsp_err;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_ptr    = 0;

  logic [2:0] t_op [4];
  logic [7:0] t_a  [4];
  logic [7:0] t_b  [4];

  alu_share_arbiter #(.DATAWIDTH(8), .NREQ(4), .MUL_LAT(2), .DIV_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      op[3*i +: 3] = t_op[i];
      a[8*i +: 8]  = t_a[i];
      b[8*i +: 8]  = t_b[i];
    end
  endtask

  // Reference: unsigned 8-bit arithmetic and per-op latency.
  function automatic void model(input int o, input int av, input int bv,
                                output int d, output int e, output int lat);
    d = 0; e = 0; lat = 1;
    case (o)
      0: d = (av + bv) % 256;
      1: d = (av - bv + 256) % 256;
      2: begin d = (av * bv) % 256; lat = 2; end
      3: begin lat = 4; if (bv == 0) begin d = 255; e = 1; end else d = av / bv; end
      4: begin lat = 4; if (bv == 0) begin d = av;  e = 1; end else d = av % bv; end
      default: e = 1;
    endcase
  endfunction

  task automatic run(input logic [3:0] mask, input int ngr, input bit hold,
                     output int last_d, output int last_e);
    logic [3:0] pend;
    int prev_cyc, prev_lat;
    pend = mask; prev_cyc = -1; prev_lat = 0; last_d = -1; last_e = -1;
    req = mask;
    drive();
    for (int g = 0; g < ngr; g++) begin
      int e_id, ed, ee, el, n;
      bit got;
      e_id = -1;
      for (int j = 0; j < 4; j++)
        if (pend[(m_ptr + j) % 4] && e_id < 0) e_id = (m_ptr + j) % 4;
      got = 0;
      for (int w = 0; w < 30 && !got; w++) begin
        @(posedge clk); #1;
        if (gnt !== 4'b0) got = 1;
      end
      chk("gnt_seen", 32'(got), 32'd1);
      if (!got) begin req = '0; return; end
      chk("gnt_onehot", 32'(gnt), 32'(1 << e_id));
      chk("busy_exec", 32'(busy), 32'd1);
      if (prev_cyc >= 0) chk("gnt_spacing", 32'(cyc - prev_cyc), 32'(prev_lat + 2));
      prev_cyc = cyc;
      model(int'(t_op[e_id]), int'(t_a[e_id]), int'(t_b[e_id]), ed, ee, el);
      prev_lat = el;
      m_ptr = (e_id + 1) % 4;
      if (!hold) begin pend[e_id] = 1'b0; req[e_id] = 1'b0; end
      t_a[e_id] = 8'($urandom);
      t_b[e_id] = 8'($urandom);
      drive();
      got = 0; n = 0;
      for (int c = 1; c <= el + 3 && !got; c++) begin
        @(posedge clk); #1;
        if (c == 1) chk("gnt_pulse", 32'(gnt), 32'd0);
        if (rsp_valid === 1'b1) begin got = 1; n = c; end
      end
      chk("rsp_latency", 32'(n), 32'(el));
      if (got) begin
        chk("rsp_id", 32'(rsp_id), 32'(e_id));
        chk("rsp_data", 32'(rsp_data), 32'(ed));
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        last_d = int'(rsp_data);
        last_e = int'(rsp_err);
        @(posedge clk); #1;
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("rsp_hold", 32'(rsp_data), 32'(ed));
        chk("idle_busy", 32'(busy), 32'd0);
      end
    end
    req = '0;
  endtask

  initial begin
    int d, e, seen;
    logic [3:0] mask;
    rst_n = 1'b0; req = '0; op = '0; a = '0; b = '0;
    for (int i = 0; i < 4; i++) begin t_op[i] = 3'd0; t_a[i] = 8'd0; t_b[i] = 8'd0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    t_op[0] = 3'd0; t_a[0] = 8'hF0; t_b[0] = 8'h20;
    run(4'b0001, 1, 1'b0, d, e);
    chk("t1_add_wrap", 32'(d), 32'h10);
    chk("t1_err", 32'(e), 32'd0);

    for (int i = 0; i < 4; i++) begin t_op[i] = 3'd0; t_a[i] = 8'($urandom); t_b[i] = 8'($urandom); end
    run(4'b1111, 5, 1'b1, d, e);

    t_op[2] = 3'd2; t_a[2] = 8'd20; t_b[2] = 8'd13;
    run(4'b0100, 1, 1'b0, d, e);
    chk("t3_mul", 32'(d), 32'h04);
    t_op[2] = 3'd3; t_a[2] = 8'd100; t_b[2] = 8'd7;
    run(4'b0100, 1, 1'b0, d, e);
    chk("t3_div", 32'(d), 32'd14);
    t_op[2] = 3'd4; t_a[2] = 8'd100; t_b[2] = 8'd7;
    run(4'b0100, 1, 1'b0, d, e);
    chk("t3_mod", 32'(d), 32'd2);

    t_op[1] = 3'd3; t_a[1] = 8'd9; t_b[1] = 8'd0;
    run(4'b0010, 1, 1'b0, d, e);
    chk("t4_div0_data", 32'(d), 32'hFF);
    chk("t4_div0_err", 32'(e), 32'd1);
    t_op[1] = 3'd4; t_a[1] = 8'd9; t_b[1] = 8'd0;
    run(4'b0010, 1, 1'b0, d, e);
    chk("t4_mod0_data", 32'(d), 32'd9);
    chk("t4_mod0_err", 32'(e), 32'd1);
    t_op[1] = 3'd6; t_a[1] = 8'd33; t_b[1] = 8'd4;
    run(4'b0010, 1, 1'b0, d, e);
    chk("t4_illegal_data", 32'(d), 32'd0);
    chk("t4_illegal_err", 32'(e), 32'd1);

    // Reset during a DIV owned by requester 1 (pointer would otherwise sit at 2).
    t_op[1] = 3'd3; t_a[1] = 8'd50; t_b[1] = 8'd3;
    req = 4'b0010; drive();
    seen = 0;
    for (int w = 0; w < 30 && seen == 0; w++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b0) seen = 1;
    end
    chk("t5_gnt", 32'(gnt), 32'b0010);
    req = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(rsp_valid), 32'd0);
    chk("t5_id", 32'(rsp_id), 32'd0);
    chk("t5_data", 32'(rsp_data), 32'd0);
    chk("t5_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    m_ptr = 0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (rsp_valid === 1'b1) seen = 1; end
    chk("t5_no_rsp", 32'(seen), 32'd0);
    t_op[1] = 3'd0; t_op[2] = 3'd1;
    run(4'b0110, 2, 1'b0, d, e);

    t_op[3] = 3'd1; t_a[3] = 8'd0; t_b[3] = 8'd1;
    run(4'b1000, 1, 1'b0, d, e);
    chk("t6_sub_captured", 32'(d), 32'hFF);

    for (int n = 0; n < 40; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        t_op[i] = 3'($urandom_range(0, 7));
        t_a[i]  = 8'($urandom);
        t_b[i]  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      end
      if (n % 8 == 7) run(mask, 6, 1'b1, d, e);
      else            run(mask, $countones(mask), 1'b0, d, e);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one registered arithmetic unit (ADD/SUB/MUL/DIV/MOD, unsigned, DATAWIDTH bits) among NREQ requesters.
- Grants in round-robin order with one operation in flight at a time.
- Models fixed per-op latencies and returns a tagged, one-cycle response.
- Sits between datapath control FSMs and the arithmetic library blocks.

Parameters:
- DATAWIDTH, 8, operand/result width in bits.
- NREQ, 4, requester count; fixed at 4 (rsp_id is 2 bits).
- MUL_LAT, 2, execute cycles for MUL (>=1).
- DIV_LAT, 4, execute cycles for DIV and MOD (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester request; held with operands stable until gnt seen.
- op  in  3*NREQ  opcode for requester i in bits [3i+2:3i]: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5-7 illegal.
- a  in  DATAWIDTH*NREQ  operand A for requester i in slice i.
- b  in  DATAWIDTH*NREQ  operand B for requester i in slice i.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of requester i captured.
- busy  out  1  high in EXEC and RESP.
- rsp_valid  out  1  one-cycle pulse: result available.
- rsp_id  out  2  index of the requester owning the result.
- rsp_data  out  DATAWIDTH  result, valid when rsp_valid is high.
- rsp_err  out  1  divide-by-zero or illegal opcode; qualified by rsp_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n=0 sampled at a rising edge).
- Reset values: gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, state=IDLE, rr_ptr=0.
- Reset mid-operation: aborts the in-flight op; no rsp_valid is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req bit is high at edge E, pick the first set bit at or after rr_ptr (wrapping).
  - Latch that requester's op, a, b and id; pulse gnt[i] in the cycle after E.
  - Set rr_ptr=(i+1) mod NREQ; go to EXEC with cnt=LAT-1.
  - With no req, stay in IDLE.
- LAT: ADD/SUB=1, MUL=MUL_LAT, DIV/MOD=DIV_LAT, illegal=1.
- EXEC: cnt decrements each cycle. When cnt==0 the result register loads; go to RESP.
- RESP: rsp_valid=1 with rsp_id, rsp_data, rsp_err for exactly one cycle, then IDLE.
- Latency: gnt in cycle E+1; rsp_valid in cycle E+1+LAT (ADD: gnt at E+1, rsp at E+2).
- Requests are not sampled in EXEC or RESP. The earliest next grant edge is the RESP cycle's next edge. Back-to-back throughput is one op per LAT+2 cycles.
- Requester rule: drop req in the cycle gnt[i] is seen, or be re-granted as a new op at the next IDLE arbitration.
- Arithmetic (unsigned, truncated to DATAWIDTH):
  - ADD: wraps mod 2^DATAWIDTH.
  - SUB: wraps (0-1 = all ones).
  - MUL: low DATAWIDTH bits of the product.
  - DIV: quotient.
  - MOD: remainder.
- Divide by zero:
  - DIV with b=0: rsp_data=all ones, rsp_err=1.
  - MOD with b=0: rsp_data=a, rsp_err=1.
  - Latency is unchanged (DIV_LAT).
- Illegal opcode: rsp_data=0, rsp_err=1, latency 1. rr_ptr still advances.
- Operand changes after capture have no effect on the in-flight result.
- Simultaneous requests: exactly one grant per arbitration. The others wait; no request is starved beyond NREQ-1 intervening grants.
- Outputs rsp_id/rsp_data/rsp_err hold their last values outside RESP; only rsp_valid qualifies them.

Test Plan:
1. Reset, then req=0001, op0=ADD, a0=8'hF0, b0=8'h20 -> gnt=0001 one cycle, then rsp_valid next cycle with rsp_id=0, rsp_data=8'h10, rsp_err=0.
2. req=1111 held continuously, all ADD -> grants in order 0,1,2,3,0; each rsp_id matches; gnt pulses 3 cycles apart.
3. Requester 2: MUL a=8'd20, b=8'd13 -> rsp_data=8'h04 (260 mod 256), rsp_valid exactly MUL_LAT=2 cycles after gnt. Then DIV a=8'd100, b=8'd7 -> 14 after 4 cycles; MOD -> 2.
4. DIV a=8'd9, b=0 -> rsp_data=8'hFF, rsp_err=1. MOD a=8'd9, b=0 -> rsp_data=8'd9, rsp_err=1. op=6 -> rsp_data=0, rsp_err=1, one cycle after gnt.
5. rst_n=0 for one cycle during EXEC of a DIV -> no rsp_valid; busy=0, all outputs 0; next req to requester 1 is granted first from rr_ptr=0 ordering.
6. SUB a=0, b=1 with operands changed to a=5 the cycle after gnt -> rsp_data=8'hFF (captured values used).
